// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with registered storage; flush beats push and pop.
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = 2 * XLEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               wr_data,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_en, pop_en;

  // Explicit wrap keeps non-power-of-two depths (the PC queue) correct.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_en) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues credited memory
// requests, buffers responses and squashes wrong-path fetches on redirect.
module fetch_unit import fetch_pkg::*; #(
  parameter int              XLEN_P          = XLEN,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc
);
  localparam int OW  = $clog2(MAX_OUTSTANDING+1);
  localparam int FCW = $clog2(FIFO_DEPTH+1);
  localparam int SW  = $clog2(FIFO_DEPTH+MAX_OUTSTANDING+1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [OW-1:0]   outstanding;
  logic            pcq_full, pcq_empty;
  logic [XLEN-1:0] rsp_pc;
  logic [FCW-1:0]  fifo_count;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  fetch_entry_t    fifo_head;
  logic            req_fire;

  // PC queue occupancy is exactly the number of requests still in flight.
  fetch_fifo #(.DEPTH(MAX_OUTSTANDING), .W(XLEN)) u_pcq (
    .clk(clk), .reset(reset),
    .push(req_fire), .pop(imem_rsp_valid && !pcq_empty), .flush(1'b0),
    .wr_data(fetch_pc_q), .rd_data(rsp_pc),
    .count(outstanding), .full(pcq_full), .empty(pcq_empty)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(2*XLEN)) u_fifo (
    .clk(clk), .reset(reset),
    .push(fifo_push), .pop(fifo_pop), .flush(redirect_valid),
    .wr_data({rsp_pc, imem_rsp_data}), .rd_data(fifo_head),
    .count(fifo_count), .full(fifo_full), .empty(fifo_empty)
  );

  // Credit check: never have more in flight than free FIFO slots.
  assign imem_req_valid = !reset && (state_q == FETCH) && !redirect_valid && !pcq_full &&
                          ((SW'(fifo_count) + SW'(outstanding)) < SW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign fifo_push = (state_q == FETCH) && imem_rsp_valid && !fifo_full;
  assign dec_valid = !reset && !fifo_empty && !redirect_valid;
  assign fifo_pop  = dec_valid && dec_ready;
  assign dec_instr = (fifo_empty || reset) ? '0 : fifo_head.instr;
  assign dec_pc    = (fifo_empty || reset) ? '0 : fifo_head.pc;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      drop_cnt_d = ((state_q == DRAIN) ? drop_cnt_q : outstanding) - OW'(imem_rsp_valid);
      state_d    = (drop_cnt_d != '0) ? DRAIN : FETCH;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(1);
      if (state_q == DRAIN) begin
        drop_cnt_d = drop_cnt_q - OW'(imem_rsp_valid);
        if (drop_cnt_d == '0) state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fixed-latency memory model, delivery log.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  fetch_unit u_dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;

  int           vec_cnt = 0;
  int           err_cnt = 0;
  int           cyc = 0;
  int           lat = 1;
  pend_t        pend[$];
  fetch_entry_t log_q[$];
  logic         o_req_v, o_dec_v;
  logic [31:0]  o_req_a, o_dec_pc, o_dec_instr;
  int           first_dv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample at negedge, then advance the memory model after the edge.
  task automatic step();
    logic fire, rv;
    @(negedge clk);
    o_req_v = imem_req_valid; o_req_a = imem_req_addr;
    o_dec_v = dec_valid; o_dec_pc = dec_pc; o_dec_instr = dec_instr;
    fire = imem_req_valid && imem_req_ready;
    rv   = imem_rsp_valid;
    if (dec_valid && dec_ready) begin
      log_q.push_back('{pc: dec_pc, instr: dec_instr});
      chk("instr_data", dec_instr, ~dec_pc);
    end
    chk("outstanding_max", 32'(pend.size() <= 2), 32'd1);
    @(posedge clk); #1;
    if (reset) pend.delete();
    else begin
      if (rv) void'(pend.pop_front());
      if (fire) pend.push_back('{addr: o_req_a, due: cyc + lat});
    end
    cyc++;
    imem_rsp_valid = (pend.size() > 0) && (pend[0].due == cyc);
    imem_rsp_data  = imem_rsp_valid ? ~pend[0].addr : 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0;
    step();
    step();
    chk("rst_req_valid", 32'(o_req_v), 32'd0);
    chk("rst_dec_valid", 32'(o_dec_v), 32'd0);
    chk("rst_dec_pc", o_dec_pc, 32'd0);
    chk("rst_dec_instr", o_dec_instr, 32'd0);
    reset = 1'b0;
    cyc = 1;
    log_q.delete();
  endtask

  initial begin
    // Streaming, latency 1
    lat = 1; dec_ready = 1'b1;
    do_reset();
    first_dv = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) begin
        chk("t1_req0_valid", 32'(o_req_v), 32'd1);
        chk("t1_req0_addr", o_req_a, 32'd0);
      end
      if (o_dec_v && first_dv == 0) first_dv = c;
    end
    chk("t1_first_dv_cycle", 32'(first_dv), 32'd3);
    chk("t1_count", 32'(log_q.size()), 32'd10);
    for (int i = 0; i < log_q.size(); i++) chk("t1_pc", log_q[i].pc, 32'(i));

    // Back-pressure
    dec_ready = 1'b0;
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c >= 3) begin
        chk("t2_hold_pc", o_dec_pc, 32'd0);
        chk("t2_hold_instr", o_dec_instr, 32'hFFFF_FFFF);
      end
    end
    chk("t2_req_stalled", 32'(o_req_v), 32'd0);
    chk("t2_dec_valid", 32'(o_dec_v), 32'd1);
    dec_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    chk("t2_count", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < log_q.size(); i++) chk("t2_pc", log_q[i].pc, 32'(i));

    // Redirect with two requests in flight, latency 3
    lat = 3;
    do_reset();
    for (int c = 1; c <= 10; c++) step();
    chk("t3_out_before", 32'(pend.size()), 32'd2);
    log_q.delete();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    for (int c = 12; c <= 20; c++) begin
      step();
      if (c == 12 || c == 13) chk("t3_drain_no_req", 32'(o_req_v), 32'd0);
      if (c == 14) begin
        chk("t3_resume_valid", 32'(o_req_v), 32'd1);
        chk("t3_resume_addr", o_req_a, 32'h40);
      end
    end
    chk("t3_count", 32'(log_q.size()), 32'd2);
    for (int i = 0; i < log_q.size(); i++) chk("t3_pc", log_q[i].pc, 32'h40 + 32'(i));

    // Redirect coincident with a response and a pending pop
    lat = 1;
    do_reset();
    for (int c = 1; c <= 5; c++) step();
    chk("t4_out_before", 32'(pend.size()), 32'd1);
    log_q.delete();
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    chk("t4_dv_suppressed", 32'(o_dec_v), 32'd0);
    chk("t4_req_blocked", 32'(o_req_v), 32'd0);
    step();
    chk("t4_next_req_valid", 32'(o_req_v), 32'd1);
    chk("t4_next_req_addr", o_req_a, 32'h10);
    chk("t4_flushed", 32'(o_dec_v), 32'd0);
    for (int c = 8; c <= 12; c++) step();
    chk("t4_count", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < log_q.size(); i++) chk("t4_pc", log_q[i].pc, 32'h10 + 32'(i));

    // Back-to-back redirects, second one during DRAIN
    lat = 3;
    do_reset();
    step(); step();
    chk("t5_out_before", 32'(pend.size()), 32'd2);
    log_q.delete();
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    chk("t5_no_req_c4", 32'(o_req_v), 32'd0);
    step();
    chk("t5_no_req_c5", 32'(o_req_v), 32'd0);
    step();
    chk("t5_req_valid", 32'(o_req_v), 32'd1);
    chk("t5_req_addr", o_req_a, 32'h80);
    for (int c = 7; c <= 12; c++) step();
    chk("t5_count", 32'(log_q.size()), 32'd2);
    for (int i = 0; i < log_q.size(); i++) chk("t5_pc", log_q[i].pc, 32'h80 + 32'(i));

    // Reset mid-stream with three buffered entries
    lat = 1; dec_ready = 1'b0;
    do_reset();
    for (int c = 1; c <= 4; c++) step();
    chk("t6_dv_before", 32'(o_dec_v), 32'd1);
    do_reset();
    dec_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) begin
        chk("t6_restart_valid", 32'(o_req_v), 32'd1);
        chk("t6_restart_addr", o_req_a, 32'd0);
      end
    end
    chk("t6_count", 32'(log_q.size()), 32'd2);
    for (int i = 0; i < log_q.size(); i++) chk("t6_pc", log_q[i].pc, 32'(i));

    // PC wrap
    do_reset();
    for (int c = 1; c <= 4; c++) step();
    log_q.delete();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    for (int c = 6; c <= 11; c++) step();
    chk("t7_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() >= 2) begin
      chk("t7_pc0", log_q[0].pc, 32'hFFFF_FFFF);
      chk("t7_pc1", log_q[1].pc, 32'h0);
      chk("t7_instr1", log_q[1].instr, 32'hFFFF_FFFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end. Sits directly upstream of the instruction-memory/decode path of the single-cycle core.
- Owns the fetch PC and issues word-addressed requests (PC advances by 1 per instruction) to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small prefetch FIFO and presents {pc, instruction} to decode with a valid/ready handshake.
- Accepts branch/jump redirects, flushing buffered and in-flight wrong-path instructions.

Parameters:
- XLEN, 32, width of PC, addresses and instructions.
- FIFO_DEPTH, 4, prefetch FIFO entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum issued-but-unanswered memory requests (>=1).
- RESET_PC, 0, fetch PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  word address of the request.
- imem_rsp_valid  in  1  response valid; responses return in request order, latency >=1 cycle, never back-pressured.
- imem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  XLEN  redirect target (word address).
- dec_valid  out  1  decode output valid.
- dec_ready  in  1  decode consumes this cycle.
- dec_instr  out  XLEN  instruction at the FIFO head.
- dec_pc  out  XLEN  address of dec_instr.

Behaviour:
- Reset, sampled at clk edge:
  - fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=FETCH.
  - Outputs: imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0.
  - Reset mid-operation discards all FIFO entries and forgets in-flight requests. The bench guarantees no responses arrive after a reset.
- Request rules:
  - imem_req_valid = !reset && state==FETCH && !redirect_valid && outstanding<MAX_OUTSTANDING && (fifo_count+outstanding)<FIFO_DEPTH.
  - imem_req_addr = fetch_pc.
  - On request handshake: fetch_pc<=fetch_pc+1 (wraps modulo 2^XLEN), outstanding+1.
  - The credit rule guarantees every response has a FIFO slot. The FIFO never overflows.
- Response rules:
  - In FETCH, imem_rsp_valid writes {pc_of_request, data} into the FIFO and decrements outstanding.
  - A per-request PC queue (depth MAX_OUTSTANDING) tracks pc_of_request.
  - A handshake and a response in the same cycle leave outstanding unchanged.
- Decode side:
  - The FIFO is registered: dec_valid=!empty. A response written at cycle N is visible at N+1 (no bypass).
  - Pop on dec_valid&&dec_ready.
  - dec_instr/dec_pc hold stable while dec_valid&&!dec_ready. Outputs are 0 when empty.
  - Simultaneous push and pop when full is impossible by construction. Push and pop on a non-empty FIFO keep the count unchanged.
- Redirect (highest priority after reset), at cycle N:
  - FIFO flushed at N+1. Any same-cycle pop is suppressed: dec_valid is forced to 0 in cycle N.
  - fetch_pc<=redirect_pc.
  - drop_cnt<=outstanding-(imem_rsp_valid?1:0). A response arriving in cycle N is itself discarded.
  - Next state: DRAIN if drop_cnt_next>0, else FETCH. The first target request can therefore issue at N+1.
- FSM:
  - FETCH: normal operation.
  - DRAIN: no requests issued. Each imem_rsp_valid is discarded, drop_cnt-1 and outstanding-1. When drop_cnt reaches 0, go to FETCH on the next cycle.
  - Redirect in DRAIN: fetch_pc updated, drop_cnt decremented only by any same-cycle response, remain in DRAIN.
- Invariant (checked by the bench): fifo_count+outstanding<=FIFO_DEPTH; outstanding<=MAX_OUTSTANDING.

Decomposition:
- Shared package fetch_pkg:
  - XLEN.
  - RESET_PC default.
  - State encoding: FETCH=0, DRAIN=1.
  - Typedef for a fetch entry {pc, instr}.
- One natural sub-module: fetch_fifo.
  - Parameterised synchronous FIFO of entries with push, pop, flush, count, full and empty.
  - Synchronous reset.
  - Flush has priority over push and pop.
- The PC queue may reuse fetch_fifo with depth MAX_OUTSTANDING.

Test Plan:
- Reset then streaming: memory latency 1, req_ready=1, dec_ready=1.
  - Requests to 0,1,2,…
  - First dec_valid at cycle 3 after reset release, dec_pc=0.
  - Thereafter one instruction per cycle with no gaps.
  - dec_instr matches memory contents.
- Back-pressure: dec_ready=0 for 10 cycles.
  - FIFO fills to 4, imem_req_valid drops to 0, dec_pc holds 0 with dec_instr stable.
  - Releasing dec_ready delivers pc 0..3 in order with no loss or duplication.
- Redirect with outstanding: latency 3, redirect to 0x40 while outstanding=2.
  - Two responses discarded, then requests resume at 0x40.
  - The next dec_pc is 0x40.
  - No wrong-path pc (e.g. 5, 6) ever appears on dec_valid.
- Redirect coincident with a response and a pending decode pop, outstanding=1, redirect to 0x10.
  - Same-cycle dec handshake suppressed (dec_valid=0), that response dropped, drop_cnt=0.
  - imem_req_addr=0x10 with valid on the next cycle.
- Back-to-back redirects: 0x20 at cycle N, 0x80 at N+1 during DRAIN.
  - Only pc 0x80 onward is delivered.
- Reset asserted mid-stream with FIFO holding 3 entries.
  - Next cycle dec_valid=0 and imem_req_valid=0.
  - After release, fetch restarts at RESET_PC=0.
  - PC wrap: redirect to 0xFFFFFFFF delivers 0xFFFFFFFF then 0x00000000.
